// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: port indices, request and response records.
package dmem_pkg;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    typedef struct packed {
        logic        we;
        logic [3:0]  strobe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request channel plus response channel.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [3:0]    req_strobe;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_strobe, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_strobe, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_rsp_buf.sv
// One-deep response register: loads on grant, holds until consumed.
module dmem_rsp_buf import dmem_pkg::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  dmem_rsp_t load_rsp,
    input  logic      rsp_ready,
    output logic      rsp_valid,
    output dmem_rsp_t rsp,
    output logic      free
);
    logic      valid_q;
    dmem_rsp_t rsp_q;

    // Consuming in the same cycle frees the slot for a back-to-back accept.
    assign free      = !valid_q || rsp_ready;
    assign rsp_valid = valid_q;
    assign rsp       = rsp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            rsp_q   <= load_rsp;
        end else if (rsp_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (port 0 CPU, port 1 debug/DMA).
// Define DMEM_ARB_P0_PRIO_EN for fixed port-0 priority instead of round robin.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic           mem_we,
    output logic [3:0]     mem_strobe,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic [31:0]    mem_rdata
);
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic [1:0]    free;
    logic [AW-1:0] sel_addr;
    logic          in_range;
    dmem_req_t     sel;
    dmem_rsp_t     load_rsp;
    dmem_rsp_t     rsp0;
    dmem_rsp_t     rsp1;

    // Nothing is granted while in reset, so no write slips through on the reset edge.
    assign elig[PORT_CPU] = !rst && p0.req_valid && free[PORT_CPU];
    assign elig[PORT_DBG] = !rst && p1.req_valid && free[PORT_DBG];

`ifdef DMEM_ARB_P0_PRIO_EN
    assign gnt[PORT_CPU] = elig[PORT_CPU];
    assign gnt[PORT_DBG] = elig[PORT_DBG] && !elig[PORT_CPU];
`else
    logic last_grant_q;

    // On a tie, the port that did not win last time is granted.
    assign gnt[PORT_CPU] = elig[PORT_CPU] && (!elig[PORT_DBG] || last_grant_q);
    assign gnt[PORT_DBG] = elig[PORT_DBG] && (!elig[PORT_CPU] || !last_grant_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (|gnt) begin
            last_grant_q <= gnt[PORT_DBG];
        end
    end
`endif

    assign p0.req_ready = gnt[PORT_CPU];
    assign p1.req_ready = gnt[PORT_DBG];

    // Port 0 drives the memory bus whenever port 1 is not granted.
    always_comb begin
        sel_addr   = gnt[PORT_DBG] ? p1.req_addr   : p0.req_addr;
        sel.we     = gnt[PORT_DBG] ? p1.req_we     : p0.req_we;
        sel.strobe = gnt[PORT_DBG] ? p1.req_strobe : p0.req_strobe;
        sel.wdata  = gnt[PORT_DBG] ? p1.req_wdata  : p0.req_wdata;
        sel.addr   = 32'(sel_addr);
    end

    assign in_range   = (sel_addr >> 2) < AW'(DEPTH);
    assign mem_we     = (|gnt) && sel.we && in_range;
    assign mem_strobe = sel.strobe;
    assign mem_addr   = sel.addr;
    assign mem_wdata  = sel.wdata;

    always_comb begin
        load_rsp.rdata = (!sel.we && in_range) ? mem_rdata : 32'h0;
        load_rsp.err   = !in_range;
    end

    dmem_rsp_buf u_buf0 (
        .clk       (clk),
        .rst       (rst),
        .load      (gnt[PORT_CPU]),
        .load_rsp  (load_rsp),
        .rsp_ready (p0.rsp_ready),
        .rsp_valid (p0.rsp_valid),
        .rsp       (rsp0),
        .free      (free[PORT_CPU])
    );

    dmem_rsp_buf u_buf1 (
        .clk       (clk),
        .rst       (rst),
        .load      (gnt[PORT_DBG]),
        .load_rsp  (load_rsp),
        .rsp_ready (p1.rsp_ready),
        .rsp_valid (p1.rsp_valid),
        .rsp       (rsp1),
        .free      (free[PORT_DBG])
    );

    assign p0.rsp_rdata = rsp0.rdata;
    assign p0.rsp_err   = rsp0.err;
    assign p1.rsp_rdata = rsp1.rdata;
    assign p1.rsp_err   = rsp1.err;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter in front of the single-port data memory (synchronous byte-strobed write, asynchronous word read).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA port.
- Grants at most one memory access per cycle, registers each read result into a per-port response buffer and returns it with valid/ready handshakes.
- Sits between the pipeline MEM stage and the data memory instance.

Parameters:
- DEPTH, 256, memory depth in 32-bit words; accesses with word index >= DEPTH are out of range.
- AW, 32, byte-address width of the request ports.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  1 = write, 0 = read.
- p0_req_strobe  in  4  byte enables, bit i covers wdata[8i+7:8i].
- p0_req_addr  in  AW  byte address; bits [1:0] ignored.
- p0_req_wdata  in  32  write data.
- p0_rsp_valid  out  1  response available.
- p0_rsp_ready  in  1  requester consumes the response.
- p0_rsp_rdata  out  32  read data; 0 for writes.
- p0_rsp_err  out  1  out-of-range access.
- p1_*  (same set as p0_*)  port 1 equivalents.
- mem_we  out  1  memory write enable.
- mem_strobe  out  4  memory byte enables.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  asynchronous read data for mem_addr.

Behaviour:
- Reset values: all rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, mem_we = 0, last_grant = 1 (port 0 wins the first tie).
- Eligibility: port i is eligible when req_valid_i && (!rsp_valid_i || rsp_ready_i). The response buffer is one deep, and consuming a response in the same cycle frees the slot.
- Arbitration is combinational each cycle:
  - One port eligible: that port is granted.
  - Both eligible: the port != last_grant is granted (round robin).
  - last_grant updates to the granted port at posedge.
- Grant outputs: req_ready_g = 1 only for the granted port g.
- Memory outputs:
  - mem_addr, mem_strobe and mem_wdata are driven from port g.
  - With no grant, the mem_* outputs are driven from port 0's request fields; only mem_we is forced 0.
- Write enable: mem_we = req_we_g && in_range, where in_range = (addr[AW-1:2] < DEPTH).
  - An out-of-range write is dropped and the memory is never touched.
- Latency: exactly 1 cycle from acceptance.
  - At the posedge after acceptance, rsp_valid_g = 1.
  - For an in-range read, rsp_rdata_g holds mem_rdata sampled in the accept cycle.
  - For a write or an out-of-range access, rsp_rdata_g = 0.
  - rsp_err_g = !in_range.
- Response hold: rsp_valid/rsp_rdata/rsp_err hold until rsp_ready. On rsp_valid && rsp_ready with no new accept, rsp_valid clears next cycle. On consume plus accept in the same cycle, the buffer is overwritten (back-to-back, full throughput).
- Read-after-write: a write followed next cycle by a read to the same word returns the new data, because the write commits at the same edge the read is registered. This is a single-port RAW and needs no bypass.
- Stalled port: a port with a pending unconsumed response and rsp_ready = 0 is ineligible. The other port may take every cycle.
- Stability rule: requesters must hold req_* stable while req_valid && !req_ready. The arbiter does not latch unaccepted requests.
- Reset mid-transaction: pending responses are discarded, and any write not yet at its posedge is not performed.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1...

Optional Feature:
Macro DMEM_ARB_P0_PRIO_EN.
- Defined: fixed priority. Port 0 always wins a tie, last_grant is unused, and port 1 may starve.
- Undefined (default): round robin as above.
- Response timing and error behaviour are identical in both builds.

Decomposition:
- Shared package dmem_pkg:
  - localparam PORT_CPU = 0 and PORT_DBG = 1.
  - Request struct typedef dmem_req_t {we, strobe, addr, wdata}.
  - Response struct typedef dmem_rsp_t {rdata, err}.
- Sub-module dmem_rsp_buf, instantiated twice: the one-deep response register with valid/ready and load/consume logic. The arbiter core holds the grant logic and mem mux.

Test Plan:
- Port 0 read addr 0x10, memory word 4 = 0xDEADBEEF, rsp_ready = 1 -> p0_req_ready same cycle; next cycle p0_rsp_valid = 1, rdata = 0xDEADBEEF, err = 0.
- Port 1 write addr 0x20, wdata 0x11223344, strobe 4'b0011, prior word 0xAABBCCDD -> word 8 = 0xAABB3344; then a port 0 read of 0x20 next cycle returns 0xAABB3344.
- Both ports read continuously, rsp_ready = 1 -> grants 0,1,0,1 over 4 cycles (round robin). With DMEM_ARB_P0_PRIO_EN -> 0,0,0,0.
- Port 0 rsp_ready = 0 with response pending, then a new p0 request -> p0_req_ready = 0, port 1 served every cycle; raise rsp_ready -> p0 accepted that same cycle.
- Write to addr 0x400 with DEPTH = 256 -> mem_we = 0, memory unchanged, next cycle rsp_err = 1, rdata = 0.
- Assert rst while both responses are pending -> next cycle all rsp_valid = 0, req_ready = 0, and the first tie after reset is granted to port 0.
